// File: rtl/spu_reqq_pkg.sv
// rtl/spu_reqq_pkg.sv - shared constants, entry layout and PCX formatter for the SPU ld/st request queue
package spu_reqq_pkg;

    localparam logic [4:0] RQ_LOAD  = 5'b00000;
    localparam logic [4:0] RQ_STORE = 5'b00001;

    localparam int PCX_W       = 123;
    localparam int PCX_VLD     = 122;
    localparam int PCX_RQ_HI   = 121;
    localparam int PCX_RQ_LO   = 117;
    localparam int PCX_NC      = 116;
    localparam int PCX_CPU_HI  = 115;
    localparam int PCX_CPU_LO  = 113;
    localparam int PCX_TID_HI  = 112;
    localparam int PCX_TID_LO  = 111;
    localparam int PCX_ADDR_HI = 103;
    localparam int PCX_ADDR_LO = 64;
    localparam int PCX_DATA_HI = 63;
    localparam int PCX_DATA_LO = 0;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ISSUE    = 2'd1;
    localparam logic [1:0] ST_WAIT_ACK = 2'd2;

    typedef struct packed {
        logic        st;
        logic [1:0]  tid;
        logic [39:0] addr;
        logic [63:0] data;
    } reqq_entry_t;

    localparam int ENTRY_W = $bits(reqq_entry_t);

    // Address bits [2:0] are carried in the entry but always zeroed on the wire
    function automatic logic [PCX_W-1:0] pcx_format(input reqq_entry_t e, input logic [2:0] cpuid);
        logic [PCX_W-1:0] p;
        p                              = '0;
        p[PCX_VLD]                     = 1'b1;
        p[PCX_RQ_HI:PCX_RQ_LO]         = e.st ? RQ_STORE : RQ_LOAD;
        p[PCX_NC]                      = 1'b1;
        p[PCX_CPU_HI:PCX_CPU_LO]       = cpuid;
        p[PCX_TID_HI:PCX_TID_LO]       = e.tid;
        p[PCX_ADDR_HI:PCX_ADDR_LO]     = {e.addr[39:3], e.addr[2:0] & 3'b000};
        p[PCX_DATA_HI:PCX_DATA_LO]     = e.st ? e.data : 64'd0;
        return p;
    endfunction

endpackage

// File: rtl/spu_reqq_fifo.sv
// rtl/spu_reqq_fifo.sv - DEPTH x W request storage with wrap-around pointers and occupancy count
module spu_reqq_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 107,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  wdata_i,
    output logic [W-1:0]  rdata_o,
    output logic          push_acc_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q;
    logic          pop_ok;

    assign full_o     = (cnt_q == CW'(DEPTH));
    assign empty_o    = (cnt_q == '0);
    assign count_o    = cnt_q;
    assign pop_ok     = pop_i && !empty_o;
    // A simultaneous pop frees the slot, so a push into a full queue is still taken
    assign push_acc_o = push_i && (!full_o || pop_ok);
    assign rdata_o    = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_acc_o) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_ok)     rd_ptr_q <= rd_ptr_q + PW'(1);
            cnt_q <= cnt_q + CW'(push_acc_o) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_acc_o) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/spu_ldst_reqq.sv
// rtl/spu_ldst_reqq.sv - SPU ld/st request queue and PCX issue FSM; watchdog under SPU_REQQ_WATCHDOG_EN
module spu_ldst_reqq
    import spu_reqq_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic              rclk,
    input  logic              reset_l,
    input  logic              spu_req_vld,
    input  logic              spu_req_st,
    input  logic [1:0]        spu_req_tid,
    input  logic [39:0]       spu_req_addr,
    input  logic [63:0]       spu_req_data,
    input  logic [2:0]        const_cpuid,
    input  logic              lsu_spu_ldst_ack,
    output logic              spu_reqq_full,
    output logic              spu_reqq_empty,
    output logic [PCX_W-1:0]  spu_ldstreq_pcx,
    output logic              spu_wen_pcx_wen,
    output logic              spu_wen_pcx_7170_sel,
    output logic              spu_reqq_timeout
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [1:0]    state_q, state_d;
    reqq_entry_t   wr_entry, head_entry;
    logic [ENTRY_W-1:0] head_bits;
    logic          fifo_empty, fifo_full, push_acc, pop;
    logic [CW-1:0] fifo_count;

    assign wr_entry = '{st: spu_req_st, tid: spu_req_tid, addr: spu_req_addr, data: spu_req_data};
    assign pop      = (state_q == ST_WAIT_ACK) && lsu_spu_ldst_ack;

    spu_reqq_fifo #(.DEPTH(DEPTH), .W(ENTRY_W), .CW(CW)) u_fifo (
        .clk_i      (rclk),
        .rst_n_i    (reset_l),
        .push_i     (spu_req_vld),
        .pop_i      (pop),
        .wdata_i    (wr_entry),
        .rdata_o    (head_bits),
        .push_acc_o (push_acc),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count)
    );

    assign head_entry = reqq_entry_t'(head_bits);

    // Incoming pushes are counted so a fresh request issues on the very next cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (!fifo_empty || push_acc) state_d = ST_ISSUE;
            ST_ISSUE:    state_d = ST_WAIT_ACK;
            ST_WAIT_ACK: if (lsu_spu_ldst_ack)
                             state_d = (fifo_count > CW'(1) || push_acc) ? ST_ISSUE : ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge rclk or negedge reset_l) begin
        if (!reset_l) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    assign spu_reqq_full        = fifo_full;
    assign spu_reqq_empty       = fifo_empty && (state_q == ST_IDLE);
    assign spu_ldstreq_pcx      = fifo_empty ? '0 : pcx_format(head_entry, const_cpuid);
    assign spu_wen_pcx_wen      = (state_q == ST_ISSUE);
    assign spu_wen_pcx_7170_sel = (state_q == ST_ISSUE);

`ifdef SPU_REQQ_WATCHDOG_EN
    logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
    logic             timeout_q, timeout_d;

    always_comb begin
        wd_cnt_d  = wd_cnt_q;
        timeout_d = timeout_q | (wd_cnt_q == '1);
        if (state_q == ST_ISSUE)
            wd_cnt_d = '0;
        else if (state_q == ST_WAIT_ACK && wd_cnt_q != '1)
            wd_cnt_d = wd_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge rclk or negedge reset_l) begin
        if (!reset_l) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign spu_reqq_timeout = timeout_q;
`else
    // No watchdog in this build; CNT_W < 1 is never a legal width, so this is constant 0
    assign spu_reqq_timeout = (CNT_W < 1);
`endif

endmodule
